// File: rtl/retry_pkg.sv
// Shared types, constants and pointer helpers for the link-layer retry buffer.
package retry_pkg;

  localparam int FLIT_W = 528;  // flit width including CRC
  localparam int PTR_W  = 8;    // pointer and counter width
  localparam int DEPTH  = 255;  // physical entries and largest legal wrap value

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    LLRB_IDLE,
    LLRB_REPLAY
  } llrb_state_e;

  // Advance a pointer by one, returning to 0 after wrap-1.
  function automatic ptr_t ptr_inc(input ptr_t p, input ptr_t wrap);
    return (p == wrap - ptr_t'(1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Forward distance from a to b around a ring of size wrap.
  function automatic ptr_t ptr_dist(input ptr_t a, input ptr_t b, input ptr_t wrap);
    return (b >= a) ? ptr_t'(b - a) : ptr_t'(b + wrap - a);
  endfunction

  // Advance p by n (n <= wrap) around a ring of size wrap.
  function automatic ptr_t ptr_add(input ptr_t p, input ptr_t n, input ptr_t wrap);
    logic [PTR_W:0] sum;
    sum = {1'b0, p} + {1'b0, n};
    if (sum >= {1'b0, wrap}) sum = sum - {1'b0, wrap};
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/llr_buffer_if.sv
// Bus bundle between the retry-buffer and its neighbours (CRC gen, MUX-2, packer).
interface llr_buffer_if;
  import retry_pkg::*;

  ptr_t  i_llr_wrap_value;
  logic  i_wr_en;
  flit_t i_flit_w_crc;
  logic  i_ack_valid;
  ptr_t  i_ack_num;
  logic  i_replay_start;
  ptr_t  i_replay_eseq;
  logic  i_rd_en;
  flit_t o_llrb_flit;
  logic  o_llrb_flit_valid;
  logic  o_replay_done;
  logic  o_replay_active;
  ptr_t  o_wrt_ptr;
  ptr_t  o_num_free_buff;
  ptr_t  o_consumed;
  logic  o_full;
  logic  o_empty;
  logic  o_err;

  modport master (
    output i_llr_wrap_value, i_wr_en, i_flit_w_crc, i_ack_valid, i_ack_num,
           i_replay_start, i_replay_eseq, i_rd_en,
    input  o_llrb_flit, o_llrb_flit_valid, o_replay_done, o_replay_active,
           o_wrt_ptr, o_num_free_buff, o_consumed, o_full, o_empty, o_err
  );

  modport slave (
    input  i_llr_wrap_value, i_wr_en, i_flit_w_crc, i_ack_valid, i_ack_num,
           i_replay_start, i_replay_eseq, i_rd_en,
    output o_llrb_flit, o_llrb_flit_valid, o_replay_done, o_replay_active,
           o_wrt_ptr, o_num_free_buff, o_consumed, o_full, o_empty, o_err
  );
endinterface

// File: rtl/llrb_mem.sv
// Simple dual-port flit store: one write port, one registered read port.
module llrb_mem
  import retry_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_wr_en,
  input  ptr_t  i_wr_addr,
  input  flit_t i_wr_data,
  input  logic  i_rd_en,
  input  ptr_t  i_rd_addr,
  output flit_t o_rd_data
);

  flit_t r_mem [0:DEPTH-1];
  flit_t r_rd_data;

  // Write port.
  // NOTE: the array has no reset so it maps onto RAM macros; only the read register is reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port; holds its last value when no read is launched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/llr_buffer.sv
// Link-layer retry buffer: stores transmitted flits, frees them on ack,
// replays from a requested sequence number on retry.
module llr_buffer
  import retry_pkg::*;
(
  input logic         i_clk,
  input logic         i_rst_n,
  llr_buffer_if.slave bus
);

  llrb_state_e r_state;
  ptr_t        r_tail;
  ptr_t        r_wrt;
  ptr_t        r_rd;
  ptr_t        r_used;
  logic        r_valid;
  logic        r_done;
  logic        r_err;

  ptr_t w_wrap;
  logic w_full;
  logic w_wr_acc;
  logic w_wr_drop;
  logic w_ack_clamp;
  ptr_t w_ack_apply;
  ptr_t w_used_next;
  logic w_rd_fire;
  ptr_t w_rd_next;
  logic w_eseq_hit;
  logic w_eseq_empty;
  logic w_replay_err;

  assign w_wrap      = bus.i_llr_wrap_value;
  assign w_full      = (r_used == w_wrap);
  assign w_wr_acc    = bus.i_wr_en && !w_full && (r_state == LLRB_IDLE);
  assign w_wr_drop   = bus.i_wr_en && !w_wr_acc;
  // Acks only ever see entries present before this cycle's write.
  assign w_ack_clamp = bus.i_ack_valid && (bus.i_ack_num > r_used);
  assign w_ack_apply = !bus.i_ack_valid ? '0 : (w_ack_clamp ? r_used : bus.i_ack_num);
  assign w_used_next = r_used + ptr_t'(w_wr_acc) - w_ack_apply;
  assign w_rd_fire   = (r_state == LLRB_REPLAY) && bus.i_rd_en;
  assign w_rd_next   = ptr_inc(r_rd, w_wrap);
  // eseq lies in [tail, wrt) when its distance from tail is below the occupancy.
  assign w_eseq_hit   = (bus.i_replay_eseq < w_wrap) &&
                        (ptr_dist(r_tail, bus.i_replay_eseq, w_wrap) < r_used);
  assign w_eseq_empty = (bus.i_replay_eseq == r_wrt);
  assign w_replay_err = bus.i_replay_start &&
                        ((r_state == LLRB_REPLAY) || (!w_eseq_hit && !w_eseq_empty));

  // Pointer, occupancy and replay FSM with registered strobes.
  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LLRB_IDLE;
      r_tail  <= '0;
      r_wrt   <= '0;
      r_rd    <= '0;
      r_used  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_used  <= w_used_next;
      r_tail  <= ptr_add(r_tail, w_ack_apply, w_wrap);
      if (w_wr_acc) r_wrt <= ptr_inc(r_wrt, w_wrap);
      r_valid <= w_rd_fire;
      r_done  <= 1'b0;
      r_err   <= w_wr_drop || w_ack_clamp || w_replay_err;
      case (r_state)
        LLRB_IDLE: begin
          if (bus.i_replay_start) begin
            if (w_eseq_hit) begin
              r_state <= LLRB_REPLAY;
              r_rd    <= bus.i_replay_eseq;
            end else if (w_eseq_empty) begin
              r_done  <= 1'b1;
            end
          end
        end
        LLRB_REPLAY: begin
          if (w_rd_fire) begin
            r_rd <= w_rd_next;
            if (w_rd_next == r_wrt) begin
              r_state <= LLRB_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= LLRB_IDLE;
      endcase
    end
  end

  llrb_mem u_mem (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wrt),
    .i_wr_data (bus.i_flit_w_crc),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (r_rd),
    .o_rd_data (bus.o_llrb_flit)
  );

  assign bus.o_llrb_flit_valid = r_valid;
  assign bus.o_replay_done     = r_done;
  assign bus.o_replay_active   = (r_state == LLRB_REPLAY);
  assign bus.o_wrt_ptr         = r_wrt;
  assign bus.o_consumed        = r_used;
  assign bus.o_num_free_buff   = w_wrap - r_used;
  assign bus.o_full            = w_full;
  assign bus.o_empty           = (r_used == '0);
  assign bus.o_err             = r_err;

endmodule

// File: tb/tb_llr_buffer.sv
// Directed bench for llr_buffer: replayed flits are checked by a scoreboard
// monitor, status outputs by direct comparisons after each step.
module tb_llr_buffer;
  import retry_pkg::*;

  typedef struct {
    flit_t flit;
    logic  valid;
    logic  done;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t q[$];

  llr_buffer_if bus ();

  llr_buffer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flit(input string name, input flit_t act, input flit_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act[31:0], exp[31:0]);
    end
  endtask

  function automatic flit_t mk(input logic [7:0] b);
    return {66{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write_one(input logic [7:0] b);
    bus.i_wr_en      = 1'b1;
    bus.i_flit_w_crc = mk(b);
    tick();
    bus.i_wr_en      = 1'b0;
  endtask

  task automatic ack(input int n);
    bus.i_ack_valid = 1'b1;
    bus.i_ack_num   = ptr_t'(n);
    tick();
    bus.i_ack_valid = 1'b0;
  endtask

  task automatic replay(input int eseq);
    bus.i_replay_start = 1'b1;
    bus.i_replay_eseq  = ptr_t'(eseq);
    tick();
    bus.i_replay_start = 1'b0;
  endtask

  task automatic expect_flit(input logic [7:0] b, input logic done);
    exp_t e;
    e.flit = mk(b); e.valid = 1'b1; e.done = done;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_left", q.size(), 0);
  endtask

  // Scoreboard monitor: every valid or done strobe must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.o_llrb_flit_valid || bus.o_replay_done)) begin
        if (q.size() == 0) begin
          check("unexpected_out", int'({bus.o_llrb_flit_valid, bus.o_replay_done}), 0);
        end else begin
          e = q.pop_front();
          check("rp_valid", int'(bus.o_llrb_flit_valid), int'(e.valid));
          if (e.valid) check_flit("rp_flit", bus.o_llrb_flit, e.flit);
          check("rp_done", int'(bus.o_replay_done), int'(e.done));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_llr_wrap_value = 8'd8;
    bus.i_wr_en = 1'b0;
    bus.i_flit_w_crc = '0;
    bus.i_ack_valid = 1'b0;
    bus.i_ack_num = '0;
    bus.i_replay_start = 1'b0;
    bus.i_replay_eseq = '0;
    bus.i_rd_en = 1'b0;
    do_reset();

    // Reset state.
    check("rst_wrt", int'(bus.o_wrt_ptr), 0);
    check("rst_used", int'(bus.o_consumed), 0);
    check("rst_free", int'(bus.o_num_free_buff), 8);
    check("rst_empty", int'(bus.o_empty), 1);
    check("rst_full", int'(bus.o_full), 0);
    check("rst_strobes", int'({bus.o_llrb_flit_valid, bus.o_replay_done,
                               bus.o_replay_active, bus.o_err}), 0);
    check_flit("rst_flit", bus.o_llrb_flit, '0);

    // Five writes.
    for (int i = 0; i < 5; i++) write_one(8'hA0 + 8'(i));
    check("w5_wrt", int'(bus.o_wrt_ptr), 5);
    check("w5_used", int'(bus.o_consumed), 5);
    check("w5_free", int'(bus.o_num_free_buff), 3);
    check("w5_empty", int'(bus.o_empty), 0);

    // Fill to 8, then a dropped 9th write.
    for (int i = 5; i < 8; i++) write_one(8'hA0 + 8'(i));
    check("fill_full", int'(bus.o_full), 1);
    check("fill_wrt", int'(bus.o_wrt_ptr), 0);
    write_one(8'hEE);
    check("drop_err", int'(bus.o_err), 1);
    check("drop_used", int'(bus.o_consumed), 8);
    tick();
    check("err_pulse", int'(bus.o_err), 0);

    // Ack 3: tail moves to 3.
    ack(3);
    check("ack_used", int'(bus.o_consumed), 5);
    check("ack_free", int'(bus.o_num_free_buff), 3);
    check("ack_full", int'(bus.o_full), 0);
    check("ack_err", int'(bus.o_err), 0);
    replay(2);
    check("tail3_err", int'(bus.o_err), 1);
    check("tail3_active", int'(bus.o_replay_active), 0);

    // Replay straddling the wrap: indices 5,6,7,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) write_one(8'hB0 + 8'(i));
    ack(4);
    write_one(8'hC6);
    write_one(8'hC7);
    write_one(8'hC0);
    write_one(8'hC1);
    check("wrap_wrt", int'(bus.o_wrt_ptr), 2);
    check("wrap_used", int'(bus.o_consumed), 6);
    expect_flit(8'hB5, 1'b0);
    expect_flit(8'hC6, 1'b0);
    expect_flit(8'hC7, 1'b0);
    expect_flit(8'hC0, 1'b0);
    expect_flit(8'hC1, 1'b1);
    bus.i_rd_en = 1'b1;
    replay(5);
    check("wrap_active", int'(bus.o_replay_active), 1);
    wait_drain(20);
    bus.i_rd_en = 1'b0;
    tick();
    check("wrap_idle", int'(bus.o_replay_active), 0);

    // Empty replay and out-of-range replay.
    do_reset();
    for (int i = 0; i < 3; i++) write_one(8'hF0 + 8'(i));
    begin
      exp_t e;
      e.flit = '0; e.valid = 1'b0; e.done = 1'b1;
      q.push_back(e);
    end
    replay(3);
    check("eseq_eq_err", int'(bus.o_err), 0);
    check("eseq_eq_active", int'(bus.o_replay_active), 0);
    wait_drain(4);
    replay(7);
    check("eseq_oor_err", int'(bus.o_err), 1);
    check("eseq_oor_active", int'(bus.o_replay_active), 0);

    // Simultaneous write and ack with used=4.
    write_one(8'hF3);
    bus.i_ack_valid = 1'b1;
    bus.i_ack_num   = 8'd1;
    write_one(8'hF4);
    bus.i_ack_valid = 1'b0;
    check("wa_used", int'(bus.o_consumed), 4);
    check("wa_wrt", int'(bus.o_wrt_ptr), 5);
    check("wa_err", int'(bus.o_err), 0);
    replay(0);
    check("wa_tail_err", int'(bus.o_err), 1);

    // Over-ack clamps to occupancy.
    ack(10);
    check("oack_used", int'(bus.o_consumed), 0);
    check("oack_err", int'(bus.o_err), 1);
    check("oack_empty", int'(bus.o_empty), 1);

    // Write and second start during REPLAY are dropped.
    write_one(8'hD5);
    write_one(8'hD6);
    expect_flit(8'hD5, 1'b0);
    expect_flit(8'hD6, 1'b1);
    replay(5);
    check("rw_active", int'(bus.o_replay_active), 1);
    write_one(8'h77);
    check("rw_err", int'(bus.o_err), 1);
    check("rw_used", int'(bus.o_consumed), 2);
    check("rw_wrt", int'(bus.o_wrt_ptr), 7);
    replay(5);
    check("rs_err", int'(bus.o_err), 1);
    check("rs_active", int'(bus.o_replay_active), 1);
    bus.i_rd_en = 1'b1;
    wait_drain(10);
    bus.i_rd_en = 1'b0;
    tick();
    check("rw_idle", int'(bus.o_replay_active), 0);
    check("rw_used2", int'(bus.o_consumed), 2);

    // Reset after two of five replay flits.
    do_reset();
    for (int i = 0; i < 5; i++) write_one(8'hE0 + 8'(i));
    expect_flit(8'hE0, 1'b0);
    expect_flit(8'hE1, 1'b0);
    bus.i_rd_en = 1'b1;
    replay(0);
    tick();
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_valid", int'(bus.o_llrb_flit_valid), 0);
    check("mr_done", int'(bus.o_replay_done), 0);
    check("mr_active", int'(bus.o_replay_active), 0);
    check("mr_empty", int'(bus.o_empty), 1);
    check("mr_used", int'(bus.o_consumed), 0);
    check_flit("mr_flit", bus.o_llrb_flit, '0);
    bus.i_rd_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mr_queue", q.size(), 0);
    check("mr_post_active", int'(bus.o_replay_active), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/llr_buffer.md
Name: llr_buffer

Overview:
- Link-layer retry buffer (LLRB) for the CXL retry path.
- Stores every CRC-protected 528-bit flit the transmitter sends, and frees entries as acknowledgements arrive.
- On a retry request, replays stored flits starting at the requested sequence number.
- Sits directly downstream of the CRC generator and feeds MUX-2 with replayed flits. Write pointer, free count and consumed count go to the control-flit packer and the register file.

Parameters:
- FLIT_W, 528, flit width including CRC.
- DEPTH, 255, physical entries; also the maximum legal wrap value.
- PTR_W, 8, pointer and counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_llr_wrap_value  in  8  capacity and pointer wrap point; legal range 2..DEPTH; static while buffer non-empty
- i_wr_en  in  1  store i_flit_w_crc at the write pointer
- i_flit_w_crc  in  528  flit from CRC generator
- i_ack_valid  in  1  acknowledgement strobe
- i_ack_num  in  8  number of oldest entries to free
- i_replay_start  in  1  begin replay (pulse)
- i_replay_eseq  in  8  sequence number of first flit to replay
- i_rd_en  in  1  consumer requests next replay flit
- o_llrb_flit  out  528  replayed flit
- o_llrb_flit_valid  out  1  o_llrb_flit valid this cycle
- o_replay_done  out  1  pulse: replay finished
- o_replay_active  out  1  high while in REPLAY
- o_wrt_ptr  out  8  next write index (eseq for outgoing flits)
- o_num_free_buff  out  8  wrap_value minus used
- o_consumed  out  8  used entries
- o_full  out  1  used == wrap_value
- o_empty  out  1  used == 0
- o_err  out  1  one-cycle pulse on any protocol error (see below)

Behaviour:
- Reset (async, active low) values:
  - All pointers 0, used 0, state IDLE.
  - o_llrb_flit 0; valid, done, active and err all 0.
  - o_empty 1, o_full 0, o_num_free_buff = i_llr_wrap_value.
  - Memory contents are not reset.
- Pointers:
  - tail: oldest unacked entry. wrt: next write. rd: next replay read.
  - next(p) = (p == wrap-1) ? 0 : p+1.
- Write: when i_wr_en && !full && state==IDLE, mem[wrt] <= flit and wrt <= next(wrt). A write while full or in REPLAY is dropped and pulses o_err.
- Ack:
  - i_ack_valid advances tail by min(i_ack_num, used), with modular arithmetic at wrap.
  - If i_ack_num > used, entries are freed up to the clamp and o_err pulses.
  - i_ack_num = 0 is a no-op.
  - Acks are accepted in both states.
- Used counter: used_next = used + wr_accepted − ack_applied.
  - Simultaneous write and ack in the same cycle are both applied.
  - An ack applies only to entries present before that cycle's write.
- States:
  - IDLE:
    - i_replay_start with eseq inside [tail, wrt), modular, → REPLAY, rd <= eseq.
    - eseq == wrt → stay IDLE; o_replay_done pulses next cycle; no flits replayed.
    - Any other eseq → stay IDLE; o_err pulses.
  - REPLAY:
    - o_replay_active = 1.
    - On i_rd_en: read mem[rd] and set rd <= next(rd). o_llrb_flit and o_llrb_flit_valid appear exactly 1 cycle later (synchronous RAM read).
    - The read where next(rd) == wrt → IDLE. o_replay_done is asserted in the same cycle as that last flit's valid.
    - i_replay_start while in REPLAY is ignored and pulses o_err.
- Output timing:
  - o_llrb_flit_valid is low in any cycle without a read launched the previous cycle.
  - o_llrb_flit holds its last value when not valid.
- Status outputs: o_wrt_ptr, o_consumed, o_num_free_buff, o_full and o_empty are registered and reflect state after the current cycle's updates.
- Wrap: every pointer crosses wrap−1 → 0 seamlessly; a replay range may straddle the wrap.
- Reset mid-replay: the replay aborts immediately with no o_replay_done, and the buffer is empty.

Decomposition:
- Shared package retry_pkg:
  - FLIT_W, PTR_W, DEPTH constants.
  - llrb_state_e enum {LLRB_IDLE, LLRB_REPLAY}.
  - Function ptr_inc(p, wrap).
  - Function ptr_dist(a, b, wrap) for modular distance.
- One sub-module, llrb_mem: simple dual-port synchronous RAM, DEPTH × FLIT_W, one write port and one registered read port, no reset on contents.

Test Plan:
- Setup wrap=8: reset; write 5 flits 0xA0..0xA4 → o_wrt_ptr=5, o_consumed=5, o_num_free_buff=3, o_empty=0.
- Full and ack: fill 8 entries → o_full=1; 9th write dropped and o_err pulses. Then ack 3 → tail=3, free=3, o_full=0.
- Replay across wrap:
  - Stimulus: wrap=8; write 6, ack 4, write 4 more (wrt=2). Replay eseq=5 with i_rd_en held.
  - Response: flits from indices 5,6,7,0,1 on consecutive cycles, each 1 cycle after its read. o_replay_done coincides with index 1; state returns to IDLE.
- Empty replay: eseq == wrt=3 → o_replay_done pulses next cycle, o_llrb_flit_valid stays 0. Out-of-range eseq=7 with tail=0, wrt=3 → o_err, no replay.
- Simultaneous events:
  - Write and ack 1 in the same cycle with used=4 → used stays 4 and the tail advances.
  - Ack 10 with used=4 → used=0, o_err pulses.
  - Write during REPLAY → dropped, o_err pulses.
- Reset mid-replay: assert i_rst_n=0 after 2 of 5 replay flits → outputs at reset values immediately, no o_replay_done, o_empty=1.
